// File: rtl/booth_pkg.sv
// booth_pkg
//   Shared definitions for the radix-4 Booth partial-product path.
//   Holds the default operand width and the widths derived from it, the
//   accumulator state encoding, and the Booth triplet codes that the
//   partial-product generator decodes.
package booth_pkg;

   localparam int BOOTH_X_W    = 9;                    // signed operand width
   localparam int BOOTH_PP_W   = BOOTH_X_W + 2;        // partial-product width
   localparam int BOOTH_NUM_PP = (BOOTH_X_W + 1) / 2;  // terms per product
   localparam int BOOTH_PROD_W = 2 * BOOTH_X_W;        // full product width

   typedef enum logic {
      ACC  = 1'b0,
      DONE = 1'b1
   } acc_state_e;

   // Multiplier triplet {y[2i+1], y[2i], y[2i-1]} -> Booth digit.
   typedef enum logic [2:0] {
      TRIP_ZERO_P = 3'b000,   //  0
      TRIP_P1_A   = 3'b001,   // +1
      TRIP_P1_B   = 3'b010,   // +1
      TRIP_P2     = 3'b011,   // +2
      TRIP_M2     = 3'b100,   // -2
      TRIP_M1_A   = 3'b101,   // -1
      TRIP_M1_B   = 3'b110,   // -1
      TRIP_ZERO_N = 3'b111    //  0
   } booth_trip_e;

endpackage

// File: rtl/booth_pp_align.sv
// booth_pp_align
//   Combinational alignment of one Booth partial product: sign-extends the
//   PP_W-bit term to PROD_W bits and shifts it left by 2*idx.
// Ports:
//   pp_i    PP_W    signed partial product
//   idx_i   IDX_W   triplet index of this term
//   term_o  PROD_W  aligned term (mod 2^PROD_W)
module booth_pp_align
   import booth_pkg::*;
#(
   parameter int PP_W   = BOOTH_PP_W,
   parameter int PROD_W = BOOTH_PROD_W,
   parameter int IDX_W  = $clog2(BOOTH_NUM_PP)
) (
   input  logic [PP_W-1:0]   pp_i,
   input  logic [IDX_W-1:0]  idx_i,
   output logic [PROD_W-1:0] term_o
);

   logic [PROD_W-1:0] ext;

   always_comb begin
      ext    = {{(PROD_W-PP_W){pp_i[PP_W-1]}}, pp_i};
      // Bits shifted past PROD_W are dropped; the sum is taken mod 2^PROD_W.
      term_o = ext << {idx_i, 1'b0};
   end

endmodule

// File: rtl/booth_pp_accumulator.sv
// booth_pp_accumulator
//   Sums a stream of NUM_PP signed Booth partial products (LS triplet first)
//   into a PROD_W-bit signed product and offers it on a valid/ready port.
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   clr         synchronous abort of the product in progress
//   pp_valid    partial product present
//   pp_ready    term accepted this cycle (high in ACC)
//   pp_data     PP_W signed partial product
//   prod_valid  product available
//   prod_ready  downstream accepts product
//   prod_data   PROD_W signed product
module booth_pp_accumulator
   import booth_pkg::*;
#(
   parameter  int X_W    = BOOTH_X_W,
   localparam int PP_W   = X_W + 2,
   localparam int NUM_PP = (X_W + 1) / 2,
   localparam int PROD_W = 2 * X_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              pp_valid,
   output logic              pp_ready,
   input  logic [PP_W-1:0]   pp_data,
   output logic              prod_valid,
   input  logic              prod_ready,
   output logic [PROD_W-1:0] prod_data
);

   localparam int IDX_W = $clog2(NUM_PP);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PP - 1);

   acc_state_e        state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [PROD_W-1:0] acc_q, acc_d;
   logic [PROD_W-1:0] term;

   booth_pp_align #(
      .PP_W   (PP_W),
      .PROD_W (PROD_W),
      .IDX_W  (IDX_W)
   ) u_align (
      .pp_i   (pp_data),
      .idx_i  (idx_q),
      .term_o (term)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      if (clr) begin
         // Abort wins over any handshake in the same cycle.
         state_d = ACC;
         idx_d   = '0;
      end else begin
         case (state_q)
            ACC: begin
               if (pp_valid) begin
                  // First term overwrites, so no explicit clear between products.
                  acc_d = (idx_q == '0) ? term : acc_q + term;
                  if (idx_q == IDX_LAST) begin
                     idx_d   = '0;
                     state_d = DONE;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end
            end
            DONE: begin
               if (prod_ready) begin
                  state_d = ACC;
               end
            end
            default: state_d = ACC;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ACC;
         idx_q   <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         acc_q   <= acc_d;
      end
   end

   // The accumulator is frozen while in DONE, so it doubles as the output register.
   assign pp_ready   = (state_q == ACC);
   assign prod_valid = (state_q == DONE);
   assign prod_data  = acc_q;

endmodule

// File: tb/tb_booth_pp_accumulator.sv
module tb_booth_pp_accumulator;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clr;
   logic        pp_valid;
   logic        pp_ready;
   logic [10:0] pp_data;
   logic        prod_valid;
   logic        prod_ready = 1'b0;
   logic [17:0] prod_data;

   int tests = 0;
   int fails = 0;
   int nprod = 0;
   int rdy_mode = 0;   // 0: always ready, 1: random, 2: held low
   logic [17:0] exp_q[$];

   booth_pp_accumulator dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (clr),
      .pp_valid   (pp_valid),
      .pp_ready   (pp_ready),
      .pp_data    (pp_data),
      .prod_valid (prod_valid),
      .prod_ready (prod_ready),
      .prod_data  (prod_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Downstream ready generator.
   always begin
      @(posedge clk);
      #1;
      case (rdy_mode)
         0:       prod_ready = 1'b1;
         1:       prod_ready = ($urandom_range(0, 3) != 0);
         default: prod_ready = 1'b0;
      endcase
   end

   // Monitor: a product handshake at the next edge pops the scoreboard.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && prod_valid === 1'b1 && prod_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_product: got 0x%0h, expected none", prod_data);
         end else begin
            logic [17:0] e;
            e = exp_q.pop_front();
            nprod++;
            $display("[TB] product %0d: data 0x%05h expected 0x%05h", nprod, prod_data, e);
            check("prod_data", 32'(prod_data), 32'(e));
         end
      end
   end

   // Tasks start and end at posedge+1.
   task automatic drive_pp(input logic [10:0] v, input int gap);
      bit took;
      took = 1'b0;
      repeat (gap) begin
         pp_valid = 1'b0;
         @(posedge clk); #1;
      end
      pp_valid = 1'b1;
      pp_data  = v;
      for (int n = 0; n < 200 && !took; n++) begin
         @(negedge clk);
         took = (pp_ready === 1'b1);
         @(posedge clk); #1;
      end
      pp_valid = 1'b0;
      if (!took) begin
         tests++;
         fails++;
         $display("FAIL pp_handshake_timeout: got pp_ready=%b, expected 1", pp_ready);
      end
   endtask

   task automatic send_stream(input logic [10:0] p0, input logic [10:0] p1, input logic [10:0] p2,
                              input logic [10:0] p3, input logic [10:0] p4,
                              input logic [17:0] exp, input bit push, input int gapmax);
      if (push) exp_q.push_back(exp);
      drive_pp(p0, $urandom_range(0, gapmax));
      drive_pp(p1, $urandom_range(0, gapmax));
      drive_pp(p2, $urandom_range(0, gapmax));
      drive_pp(p3, $urandom_range(0, gapmax));
      drive_pp(p4, $urandom_range(0, gapmax));
      check("prod_valid_after_last_pp", 32'(prod_valid), 32'd1);
   endtask

   initial begin
      logic [8:0]  xr, yr;
      logic [10:0] ye;
      logic [10:0] pps[5];
      int          xs, ys, dg, ppi, prodi;
      logic [17:0] e18;

      rst_n    = 1'b0;
      clr      = 1'b0;
      pp_valid = 1'b0;
      pp_data  = '0;
      #12;
      check("reset_pp_ready", 32'(pp_ready), 32'd1);
      check("reset_prod_valid", 32'(prod_valid), 32'd0);
      check("reset_prod_data", 32'(prod_data), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed products
      rdy_mode = 0;
      send_stream(11'd3, 11'd3, 11'd0, 11'd0, 11'd0, 18'd15, 1'b1, 0);        // 3*5
      send_stream(11'd0, 11'd0, 11'd0, 11'd0, 11'h100, 18'h10000, 1'b1, 0);   // -256*-256
      send_stream(11'h7F9, 11'd0, 11'd0, 11'd0, 11'd0, 18'h3FFF9, 1'b1, 0);   // 7*-1

      // Backpressure: 2 + 1*4 = 6 held for 10 cycles, pp_valid ignored in DONE
      rdy_mode = 2;
      @(posedge clk); #1;
      send_stream(11'd2, 11'd1, 11'd0, 11'd0, 11'd0, 18'd6, 1'b1, 0);
      pp_valid = 1'b1;
      pp_data  = 11'h155;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("hold_prod_valid", 32'(prod_valid), 32'd1);
         check("hold_pp_ready", 32'(pp_ready), 32'd0);
         check("hold_prod_data", 32'(prod_data), 32'd6);
      end
      pp_valid = 1'b0;
      @(posedge clk); #1;
      rdy_mode = 0;
      send_stream(11'd1, 11'd0, 11'd0, 11'd0, 11'd0, 18'd1, 1'b1, 0);

      // clr while a product waits in DONE
      rdy_mode = 2;
      @(posedge clk); #1;
      send_stream(11'd5, 11'd0, 11'd0, 11'd0, 11'd0, 18'd5, 1'b0, 0);
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      check("clr_done_prod_valid", 32'(prod_valid), 32'd0);
      check("clr_done_pp_ready", 32'(pp_ready), 32'd1);
      rdy_mode = 0;

      // clr after 3 handshakes, with a concurrent (discarded) pp
      drive_pp(11'd7, 0);
      drive_pp(11'd7, 0);
      drive_pp(11'd7, 0);
      clr      = 1'b1;
      pp_valid = 1'b1;
      pp_data  = 11'd5;
      @(posedge clk); #1;
      clr      = 1'b0;
      pp_valid = 1'b0;
      check("clr_mid_prod_valid", 32'(prod_valid), 32'd0);
      send_stream(11'd3, 11'd3, 11'd0, 11'd0, 11'd0, 18'd15, 1'b1, 0);

      // Async reset after 2 handshakes (partial sum -1 + -4 = -5)
      drive_pp(11'h7FF, 0);
      drive_pp(11'h7FF, 0);
      rst_n = 1'b0;
      #1;
      check("rst_mid_pp_ready", 32'(pp_ready), 32'd1);
      check("rst_mid_prod_valid", 32'(prod_valid), 32'd0);
      check("rst_mid_prod_data", 32'(prod_data), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      send_stream(11'd0, 11'd0, 11'd0, 11'd0, 11'h100, 18'h10000, 1'b1, 0);

      // Random operands with gaps and backpressure
      rdy_mode = 1;
      for (int t = 0; t < 1000; t++) begin
         xr = 9'($urandom_range(0, 511));
         yr = 9'($urandom_range(0, 511));
         xs = int'($signed(xr));
         ys = int'($signed(yr));
         ye = {yr[8], yr, 1'b0};
         for (int i = 0; i < 5; i++) begin
            dg = -2 * int'(ye[2*i+2]) + int'(ye[2*i+1]) + int'(ye[2*i]);
            ppi = dg * xs;
            pps[i] = ppi[10:0];
         end
         prodi = xs * ys;
         e18 = prodi[17:0];
         send_stream(pps[0], pps[1], pps[2], pps[3], pps[4], e18, 1'b1, 2);
      end

      rdy_mode = 0;
      for (int n = 0; n < 1000 && exp_q.size() != 0; n++) @(posedge clk);
      #1;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/booth_pp_accumulator.md
# booth_pp_accumulator

Sequential accumulator at the consuming end of the radix-4 Booth partial-product interface. It accepts a stream of signed Booth partial products, one per multiplier triplet, with the least-significant triplet first. Each term is aligned by 2·index bits and summed into a full-width signed product. The product is then presented on a valid/ready output. It sits between the per-triplet partial-product generator and the filter MAC in the approximate HPF datapath.

## Interface
Parameters:
- X_W, 9, signed multiplicand/multiplier width.
- PP_W, X_W+2 (derived, localparam), partial-product width.
- NUM_PP, (X_W+1)/2 = 5 (derived), partial products per product.
- PROD_W, 2·X_W = 18 (derived), product width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous abort; discards any partial accumulation.
- pp_valid  in  1  partial product present.
- pp_ready  out  1  block accepts the partial product this cycle.
- pp_data  in  PP_W  signed two's-complement partial product.
- prod_valid  out  1  product available.
- prod_ready  in  1  downstream accepts the product.
- prod_data  out  PROD_W  signed product.

## Operation
- States: ACC and DONE. Index counter idx runs 0..NUM_PP-1. Accumulator acc is PROD_W bits.
- ACC:
  - pp_ready=1.
  - On a pp handshake, acc ← acc + (sext(pp_data, PROD_W) << 2·idx), truncated mod 2^PROD_W.
  - On the first term (idx=0), acc ← the aligned term; the old acc value is ignored.
  - idx increments on each handshake.
  - On the handshake with idx=NUM_PP-1: idx←0 and the state goes to DONE.
- DONE:
  - pp_ready=0, prod_valid=1, prod_data=acc.
  - prod_data holds stable until prod_ready=1, then the state returns to ACC.
- Width rule: the full 9×9 signed range fits 18 bits, including (−256)·(−256)=65536. No overflow detection is required.
- clr:
  - In any state, clr forces idx←0 and the state to ACC, and drops prod_valid the next cycle.
  - A pp handshake in the same cycle as clr is discarded.
  - clr has priority over every other event.
- pp_valid while in DONE is ignored; pp_ready=0, so there is no handshake.
- A zero partial product (triplet 000/111) counts as a term and advances idx.

## Timing
- Reset values: state=ACC, idx=0, acc=0, pp_ready=1, prod_valid=0, prod_data=0.
- prod_valid asserts in the cycle after the NUM_PP-th pp handshake.
- Minimum period is NUM_PP+1 cycles per product. The DONE cycle cannot accept a partial product.
- pp stream may stall: pp_valid=0 cycles hold idx and acc.
- Output backpressure: DONE persists indefinitely while prod_ready=0.
- Reset mid-product: asynchronous return to reset values; the partial sum is lost.
- All outputs are registered, except that pp_ready is decoded from state only.

## Structure
- Shared package booth_pkg holds:
  - the X_W default, PP_W, NUM_PP and PROD_W localparams;
  - the state enum (ACC, DONE);
  - the Booth triplet codes, shared with the generator.
- Sub-module booth_pp_align: combinational sign-extend and shift of pp_data by 2·idx to PROD_W. It is reused by a future parallel-tree variant.
- The top holds the FSM, idx counter, accumulator and output register.

## Test plan
- x=3, y=5: pp stream 3,3,0,0,0 -> prod_data=15, prod_valid in the cycle after the 5th handshake.
- x=−256, y=−256: pp stream 0,0,0,0,0x100 -> prod_data=0x10000 (65536).
- x=7, y=−1: pp stream 0x7F9 (−7),0,0,0,0 -> prod_data=0x3FFF9 (−7).
- prod_ready held 0 for 10 cycles in DONE:
  - prod_data stays stable and pp_ready=0 throughout;
  - after release, the next stream 1,0,0,0,0 -> 1.
- clr after 3 handshakes, then a fresh stream 3,3,0,0,0 -> 15, showing the earlier terms were discarded.
- rst_n asserted after 2 handshakes -> all outputs at reset values immediately; the next full stream produces the correct product.
- Random pp_valid/prod_ready gaps over 1000 random x,y -> every product equals x·y.
